random_phase_scheduler: RTL and testbench

//  Synthesizable on-chip sequencer producing a two-phase (0/1) schedule with pseudo-random phase lengths

---
 rtl/random_phase_scheduler_pkg.sv | 35 +++
 rtl/random_phase_scheduler_if.sv | 22 ++
 rtl/random_phase_scheduler_lfsr.sv | 38 +++
 rtl/random_phase_scheduler.sv | 158 +++++++++++++++
 tb/tb_random_phase_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/random_phase_scheduler_pkg.sv
// Shared types, constants and the phase-length scaling function for the
// random phase scheduler.
package random_phase_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PHASE0 = 2'd1,
    PHASE1 = 2'd2
  } state_t;

  // Galois feedback mask for the 32-bit phase-length LFSR.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Maps the low `width` LFSR bits uniformly onto [lo, hi]:
  //   lo + ((lfsr_bits * (hi - lo + 1)) >> width)
  // The span is carried in 33 bits so hi - lo + 1 never overflows, and the
  // product in 65 bits. The result is always in [lo, hi] when lo <= hi.
  function automatic logic [31:0] scale_to_range(
    input logic [31:0] lfsr,
    input logic [31:0] lo,
    input logic [31:0] hi,
    input int          width
  );
    logic [32:0] span;
    logic [64:0] mask;
    logic [64:0] prod;
    logic [64:0] scaled;
    span   = {1'b0, hi} - {1'b0, lo} + 33'd1;
    mask   = (65'd1 << width) - 65'd1;
    prod   = ({33'd0, lfsr} & mask) * {32'd0, span};
    scaled = prod >> width;
    return 32'({33'd0, lo} + scaled);
  endfunction

endpackage

// File: rtl/random_phase_scheduler_if.sv
// Configuration port of the random phase scheduler: a valid/ready offer of
// the two [min,max] phase-length windows.
interface random_phase_scheduler_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 i_cfg_valid;
  logic                 o_cfg_ready;
  logic [CNT_WIDTH-1:0] i_state_0_min;
  logic [CNT_WIDTH-1:0] i_state_0_max;
  logic [CNT_WIDTH-1:0] i_state_1_min;
  logic [CNT_WIDTH-1:0] i_state_1_max;

  modport master (
    output i_cfg_valid, i_state_0_min, i_state_0_max, i_state_1_min, i_state_1_max,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid, i_state_0_min, i_state_0_max, i_state_1_min, i_state_1_max,
    output o_cfg_ready
  );
endinterface

// File: rtl/random_phase_scheduler_lfsr.sv
// 32-bit right-shifting Galois LFSR that advances only when asked to.
// o_value is the current (pre-step) state.
module lfsr_galois32
  import random_phase_scheduler_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1ACE_B00C
) (
  input  logic        i_clk,
  input  logic        i_a_rst,
  input  logic        i_step,
  output logic [31:0] o_value
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1.
  localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // Next state: shift right, fold in the taps when the bit shifted out is 1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (i_step) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    end
  end

  // State register, reseeded on reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) lfsr_q <= SEED_NZ;
    else         lfsr_q <= lfsr_d;
  end

  assign o_value = lfsr_q;

endmodule

// File: rtl/random_phase_scheduler.sv
// Two-phase sequencer with pseudo-random phase lengths drawn from
// programmable [min,max] windows. Config is accepted only while idle.
module random_phase_scheduler
  import random_phase_scheduler_pkg::*;
#(
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] LFSR_SEED = 32'h1ACE_B00C
) (
  input  logic                      i_clk,
  input  logic                      i_a_rst,
  input  logic                      i_en,
  random_phase_scheduler_if.slave   cfg_if,
  output logic                      o_state,
  output logic                      o_phase_start,
  output logic                      o_cfg_error,
  output logic                      o_busy
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  cnt_t   limit_q, limit_d;
  cnt_t   min0_q, min0_d, max0_q, max0_d;
  cnt_t   min1_q, min1_d, max1_q, max1_d;
  logic   cfg_loaded_q, cfg_loaded_d;
  logic   cfg_error_q, cfg_error_d;
  logic   cfg_ready_q, cfg_ready_d;
  logic   phase_start_q, phase_start_d;

  logic        lfsr_step;
  logic [31:0] lfsr_value;
  cnt_t        limit0_w, limit1_w;
  logic        cfg_xfer;
  logic        cfg_ok;

  lfsr_galois32 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_a_rst (i_a_rst),
    .i_step  (lfsr_step),
    .o_value (lfsr_value)
  );

  // Candidate limits for the next phase, from the pre-step LFSR value.
  assign limit0_w = cnt_t'(scale_to_range(lfsr_value, 32'(min0_q), 32'(max0_q), CNT_WIDTH));
  assign limit1_w = cnt_t'(scale_to_range(lfsr_value, 32'(min1_q), 32'(max1_q), CNT_WIDTH));

  assign cfg_xfer = cfg_if.i_cfg_valid && cfg_ready_q;
  assign cfg_ok   = (cfg_if.i_state_0_min <= cfg_if.i_state_0_max) &&
                    (cfg_if.i_state_1_min <= cfg_if.i_state_1_max);

  // Config handshake, phase FSM, counter and limit selection.
  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave a
    // signal unassigned and infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    limit_d       = limit_q;
    min0_d        = min0_q;
    max0_d        = max0_q;
    min1_d        = min1_q;
    max1_d        = max1_q;
    cfg_loaded_d  = cfg_loaded_q;
    cfg_error_d   = cfg_error_q;
    phase_start_d = 1'b0;
    lfsr_step     = 1'b0;

    if (cfg_xfer) begin
      if (cfg_ok) begin
        min0_d       = cfg_if.i_state_0_min;
        max0_d       = cfg_if.i_state_0_max;
        min1_d       = cfg_if.i_state_1_min;
        max1_d       = cfg_if.i_state_1_max;
        cfg_loaded_d = 1'b1;
        cfg_error_d  = 1'b0;
      end else begin
        cfg_error_d  = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (i_en && cfg_loaded_q && !cfg_xfer) begin
          state_d       = PHASE0;
          cnt_d         = '0;
          limit_d       = limit0_w;
          lfsr_step     = 1'b1;
          phase_start_d = 1'b1;
        end
      end
      PHASE0: begin
        if (cnt_q == limit_q) begin
          state_d       = PHASE1;
          cnt_d         = '0;
          limit_d       = limit1_w;
          lfsr_step     = 1'b1;
          phase_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      PHASE1: begin
        if (cnt_q == limit_q) begin
          if (i_en) begin
            state_d       = PHASE0;
            cnt_d         = '0;
            limit_d       = limit0_w;
            lfsr_step     = 1'b1;
            phase_start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cfg_ready_d = (state_d == IDLE);
  end

  // All scheduler state; reset returns to IDLE with the config discarded.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      limit_q       <= '0;
      min0_q        <= '0;
      max0_q        <= '0;
      min1_q        <= '0;
      max1_q        <= '0;
      cfg_loaded_q  <= 1'b0;
      cfg_error_q   <= 1'b0;
      cfg_ready_q   <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      limit_q       <= limit_d;
      min0_q        <= min0_d;
      max0_q        <= max0_d;
      min1_q        <= min1_d;
      max1_q        <= max1_d;
      cfg_loaded_q  <= cfg_loaded_d;
      cfg_error_q   <= cfg_error_d;
      cfg_ready_q   <= cfg_ready_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign o_state            = (state_q == PHASE1);
  assign o_busy             = (state_q != IDLE);
  assign o_phase_start      = phase_start_q;
  assign o_cfg_error        = cfg_error_q;
  assign cfg_if.o_cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_random_phase_scheduler.sv
// Self-checking bench for random_phase_scheduler: config acceptance table,
// hand-written multi-cycle sequences, and LFSR-driven phase lengths compared
// against an arithmetic model of the phase-length rules.
module tb_random_phase_scheduler;

  localparam int          W    = 16;
  localparam logic [31:0] SEED = 32'h1ACE_B00C;

  logic i_clk = 1'b0;
  logic i_a_rst = 1'b1;
  logic i_en = 1'b0;
  logic o_state, o_phase_start, o_cfg_error, o_busy;

  random_phase_scheduler_if #(.CNT_WIDTH(W)) cfg_if ();

  random_phase_scheduler #(.CNT_WIDTH(W), .LFSR_SEED(SEED)) dut (
    .i_clk         (i_clk),
    .i_a_rst       (i_a_rst),
    .i_en          (i_en),
    .cfg_if        (cfg_if),
    .o_state       (o_state),
    .o_phase_start (o_phase_start),
    .o_cfg_error   (o_cfg_error),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_lfsr   = SEED;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; inputs driven and outputs sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference LFSR: 32-bit right-shift Galois with the documented taps.
  function automatic logic [31:0] m_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  // Reference phase limit: min + floor(low_bits * (max - min + 1) / 2^W).
  function automatic longint unsigned m_limit(input logic [31:0] v, input longint unsigned lo,
                                              input longint unsigned hi);
    longint unsigned bits;
    bits = {48'd0, v[15:0]};
    return lo + (bits * (hi - lo + 1)) / (64'd1 << W);
  endfunction

  task automatic do_reset();
    i_en = 1'b0;
    cfg_if.i_cfg_valid = 1'b0;
    #2 i_a_rst = 1'b1;
    #1;
    check("rst_state", o_state, 0);
    check("rst_busy", o_busy, 0);
    check("rst_phase_start", o_phase_start, 0);
    check("rst_cfg_error", o_cfg_error, 0);
    step();
    step();
    i_a_rst = 1'b0;
    m_lfsr = SEED;
    step();
    check("rst_cfg_ready", cfg_if.o_cfg_ready, 1);
  endtask

  task automatic load_cfg(input int lo0, input int hi0, input int lo1, input int hi1);
    int n = 0;
    while (!cfg_if.o_cfg_ready && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) check("cfg_ready_timeout", 0, 1);
    cfg_if.i_cfg_valid   = 1'b1;
    cfg_if.i_state_0_min = W'(lo0);
    cfg_if.i_state_0_max = W'(hi0);
    cfg_if.i_state_1_min = W'(lo1);
    cfg_if.i_state_1_max = W'(hi1);
    step();
    cfg_if.i_cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check("idle_timeout", 0, 1);
  endtask

  // Runs nph phases with i_en held high and compares each phase's state and
  // length with the reference model.
  task automatic run_random(input int lo0, input int hi0, input int lo1, input int hi1,
                            input int nph, input bit want_distinct);
    bit seen0[int];
    bit seen1[int];
    int n;
    int len;
    int lo, hi;
    longint unsigned exp_lim;
    do_reset();
    load_cfg(lo0, hi0, lo1, hi1);
    i_en = 1'b1;
    step();
    n = 0;
    while (!o_phase_start && n < 10) begin
      step();
      n++;
    end
    check("first_phase_start", o_phase_start, 1);
    for (int p = 0; p < nph; p++) begin
      lo = (p % 2 == 0) ? lo0 : lo1;
      hi = (p % 2 == 0) ? hi0 : hi1;
      exp_lim = m_limit(m_lfsr, longint'(lo), longint'(hi));
      m_lfsr = m_step(m_lfsr);
      check("phase_state", o_state, p % 2);
      len = 1;
      step();
      while (!o_phase_start && len <= hi + 1) begin
        len++;
        step();
      end
      check("phase_len", len, exp_lim + 1);
      check("limit_in_range", ((len - 1) >= lo) && ((len - 1) <= hi), 1);
      if (p % 2 == 0) seen0[len - 1] = 1'b1;
      else            seen1[len - 1] = 1'b1;
    end
    if (want_distinct) begin
      check("distinct_limits_0", seen0.num() >= 8, 1);
      check("distinct_limits_1", seen1.num() >= 8, 1);
    end
    i_en = 1'b0;
  endtask

  typedef struct {
    bit        do_rst;
    int        mn0, mx0, mn1, mx1;
    bit        exp_err;
    bit        exp_busy;
  } cfg_vec_t;

  cfg_vec_t cfg_tab[5];

  initial begin
    cfg_if.i_cfg_valid   = 1'b0;
    cfg_if.i_state_0_min = '0;
    cfg_if.i_state_0_max = '0;
    cfg_if.i_state_1_min = '0;
    cfg_if.i_state_1_max = '0;

    // Config acceptance table: error flag, and whether i_en can start a run.
    cfg_tab[0] = '{1'b1, 5, 4, 3, 3, 1'b1, 1'b0};
    cfg_tab[1] = '{1'b0, 1, 2, 3, 3, 1'b0, 1'b1};
    cfg_tab[2] = '{1'b0, 1, 1, 9, 2, 1'b1, 1'b1};
    cfg_tab[3] = '{1'b1, 4, 4, 0, 7, 1'b0, 1'b1};
    cfg_tab[4] = '{1'b1, 0, 0, 8, 6, 1'b1, 1'b0};

    do_reset();

    // Fixed lengths 3/3: 4 cycles per phase, first start one cycle after i_en.
    load_cfg(3, 3, 3, 3);
    check("fixed_cfg_error", o_cfg_error, 0);
    i_en = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      check("fixed_state", o_state, (k / 4) % 2);
      check("fixed_phase_start", o_phase_start, (k % 4) == 0);
      check("fixed_busy", o_busy, 1);
      if (k < 15) step();
    end
    // Still in PHASE1 here: asynchronous reset must clear outputs at once.
    check("pre_reset_in_phase1", o_state, 1);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      if (cfg_tab[i].do_rst) do_reset();
      load_cfg(cfg_tab[i].mn0, cfg_tab[i].mx0, cfg_tab[i].mn1, cfg_tab[i].mx1);
      check("tab_cfg_error", o_cfg_error, cfg_tab[i].exp_err);
      i_en = 1'b1;
      step();
      check("tab_busy", o_busy, cfg_tab[i].exp_busy);
      check("tab_phase_start", o_phase_start, cfg_tab[i].exp_busy);
      step();
      check("tab_busy_hold", o_busy, cfg_tab[i].exp_busy);
      i_en = 1'b0;
      wait_idle();
    end

    // Stop request in PHASE0: 3-cycle PHASE0 and 4-cycle PHASE1 still complete.
    do_reset();
    load_cfg(2, 2, 3, 3);
    i_en = 1'b1;
    step();
    i_en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check("stop_state", o_state, (k >= 3) && (k < 7));
      check("stop_busy", o_busy, k < 7);
      check("stop_phase_start", o_phase_start, (k == 0) || (k == 3));
      step();
    end

    // Zero-length windows: single-cycle phases toggling every cycle.
    do_reset();
    load_cfg(0, 0, 0, 0);
    i_en = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      check("zero_state", o_state, k % 2);
      check("zero_phase_start", o_phase_start, 1);
      step();
    end
    i_en = 1'b0;

    // Reference windows over 1000 phases from the default seed.
    run_random(10, 20, 30, 40, 1000, 1'b1);

    // Full-range phase-1 window: long phase, no counter wrap.
    run_random(0, 0, 0, 16'hFFFF, 2, 1'b0);

    // Random small windows.
    for (int r = 0; r < 3; r++) begin
      int lo0, hi0, lo1, hi1;
      lo0 = int'($urandom_range(0, 15));
      hi0 = lo0 + int'($urandom_range(0, 20));
      lo1 = int'($urandom_range(0, 15));
      hi1 = lo1 + int'($urandom_range(0, 20));
      run_random(lo0, hi0, lo1, hi1, 40, 1'b0);
    end

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
